// File: rtl/src_ctrl_pkg.sv
// src_ctrl_pkg: opcodes, FSM states, IR field layout and opcode classification for the Mini-SRC control unit
package src_ctrl_pkg;
    localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,
                           OP_SHR  = 5'd7,  OP_SHRA = 5'd8,  OP_SHL  = 5'd9,  OP_ROR  = 5'd10,
                           OP_ROL  = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14,
                           OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18,
                           OP_NOP  = 5'd26, OP_HALT = 5'd27;
    localparam int OP_MSB = 31, OP_LSB = 27, RA_LSB = 23, RB_LSB = 19, RC_LSB = 15;
    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
    typedef enum logic [2:0] {C_REG, C_IMM, C_MD, C_UN, C_NOP, C_HALT, C_ILL} op_class_t;
    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: return C_REG;
            OP_ADDI, OP_ANDI, OP_ORI: return C_IMM;
            OP_MUL, OP_DIV: return C_MD;
            OP_NEG, OP_NOT: return C_UN;
            OP_NOP: return C_NOP;
            OP_HALT: return C_HALT;
            default: return C_ILL;
        endcase
    endfunction
endpackage

// File: rtl/src_control_sequencer_reg_select.sv
// reg_select: 4-to-16 one-hot register enable decoder
module reg_select (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);
    assign onehot = en ? 16'(1) << sel : '0;
endmodule

// File: rtl/src_control_sequencer.sv
// src_control_sequencer: hardwired Mini-SRC control unit stepping fetch/execute micro-steps T0..T6
module src_control_sequencer
    import src_ctrl_pkg::*;
#(
    parameter int READ_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Cout,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  opcode,
    output logic [15:0] r_in,
    output logic [15:0] r_out,
    output logic        run,
    output logic        illegal,
    output logic        mem_err
);
    localparam int CW = $clog2(READ_TIMEOUT + 1);
    state_t        state;
    op_class_t     cls;
    logic [CW-1:0] wait_cnt;
    logic [4:0]    op;
    logic [3:0]    ra, rb, rc, rin_sel, rout_sel;
    logic          rin_en, rout_en;
    logic          unused_ir;
    assign op        = ir[OP_MSB:OP_LSB];
    assign ra        = ir[RA_LSB+:4];
    assign rb        = ir[RB_LSB+:4];
    assign rc        = ir[RC_LSB+:4];
    assign unused_ir = ^ir[RC_LSB-1:0];
    assign cls       = op_class(op);
    assign run       = state != HALT;
    always_ff @(posedge clock) begin
        if (!clear) begin
            state    <= T0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                T0: begin
                    state    <= T1;
                    wait_cnt <= '0;
                end
                T1: begin
                    if (mem_ready) state <= T2;
                    else if (wait_cnt == CW'(READ_TIMEOUT - 1)) begin
                        state   <= HALT;
                        mem_err <= 1'b1;
                    end else wait_cnt <= wait_cnt + 1'b1;
                end
                T2: state <= T3;
                T3: state <= (cls == C_HALT) ? HALT : (cls inside {C_NOP, C_ILL}) ? T0 : T4;
                T4: state <= (cls == C_UN) ? T0 : T5;
                T5: state <= (cls == C_MD) ? T6 : T0;
                T6: state <= T0;
                HALT: state <= HALT;
            endcase
        end
    end
    // MDRin is the only strobe that looks at an input; everything else follows state and ir
    always_comb begin
        {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Cout,
         Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin} = '0;
        opcode   = '0;
        illegal  = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rin_sel  = ra;
        rout_sel = rb;
        case (state)
            T0: {PCout, MARin, IncPC, Zlowin, Zhighin} = '1;
            T1: begin
                {Zlowout, PCin, Read} = '1;
                MDRin = mem_ready;
            end
            T2: {MDRout, IRin} = '1;
            T3: case (cls)
                C_REG, C_IMM: {rout_en, Yin} = '1;
                C_MD: begin
                    {rout_en, Yin} = '1;
                    rout_sel = ra;
                end
                C_UN: begin
                    {rout_en, Zlowin, Zhighin} = '1;
                    opcode = op;
                end
                C_ILL: illegal = 1'b1;
                default: ;
            endcase
            T4: case (cls)
                C_REG: begin
                    {rout_en, Zlowin, Zhighin} = '1;
                    rout_sel = rc;
                    opcode = op;
                end
                C_IMM: begin
                    {Cout, Zlowin, Zhighin} = '1;
                    opcode = op;
                end
                C_MD: begin
                    {rout_en, Zlowin, Zhighin} = '1;
                    opcode = op;
                end
                C_UN: {Zlowout, rin_en} = '1;
                default: ;
            endcase
            T5: {Zlowout, LOin, rin_en} = (cls == C_MD) ? 3'b110 : (cls inside {C_REG, C_IMM}) ? 3'b101 : 3'b000;
            T6: {Zhighout, HIin} = {2{cls == C_MD}};
            default: ;
        endcase
    end
    reg_select u_rin  (.en(rin_en),  .sel(rin_sel),  .onehot(r_in));
    reg_select u_rout (.en(rout_en), .sel(rout_sel), .onehot(r_out));
endmodule
